// File: rtl/auth_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : auth_req_sequencer
// Purpose  : Issues one authentication request (CHALLENGE, DIGESTS or
//            CERTIFICATE) per accepted command. It builds the message header
//            and the USB control fields, waits for the transport handshake,
//            then waits for the responder's reply. Busy replies and timeouts
//            cause a resend, up to MAX_RETRY times.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            abort               - cancel the current request (no done/fail)
//            req_valid/req_ready - request handshake (req_type, req_slot)
//            tx_valid/tx_ready   - message handshake (tx_header, tx_bm...,
//                                  tx_bRequest, tx_wLength)
//            rsp_valid/rsp_error - responder reply and error flag
//            busy_in             - responder busy indication
//            done/fail           - one-cycle completion pulses
//            fail_code           - 1 retries exhausted, 2 error reply,
//                                  3 invalid request
//            retry_cnt           - retransmissions used for this request
// Revision : 1.0 - initial release
// ============================================================================
module auth_req_sequencer #(
  parameter int          NUM_SLOTS = 3,
  parameter int          SLOT_W    = 2,
  parameter int          TMO_W     = 16,
  parameter int          MAX_RETRY = 2,
  parameter int          TMO_CHAL  = 100,
  parameter int          TMO_DIG   = 50,
  parameter int          TMO_CERT  = 200,
  parameter logic [7:0]  PROTO_VER = 8'h10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_type,
  input  logic [SLOT_W-1:0] req_slot,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       tx_header,
  output logic [7:0]        tx_bmRequestType,
  output logic [7:0]        tx_bRequest,
  output logic [15:0]       tx_wLength,
  input  logic              rsp_valid,
  input  logic              rsp_error,
  input  logic              busy_in,
  output logic              done,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [1:0]        retry_cnt
);

  localparam logic [1:0]       c_TYPE_CHAL = 2'd1;
  localparam logic [1:0]       c_TYPE_DIG  = 2'd2;
  localparam logic [1:0]       c_TYPE_CERT = 2'd3;
  localparam logic [1:0]       c_MAX_RETRY = 2'(MAX_RETRY);
  localparam logic [TMO_W-1:0] c_TMO_CHAL  = TMO_W'(TMO_CHAL);
  localparam logic [TMO_W-1:0] c_TMO_DIG   = TMO_W'(TMO_DIG);
  localparam logic [TMO_W-1:0] c_TMO_CERT  = TMO_W'(TMO_CERT);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SEND  = 6'b000010,
    S_WAIT  = 6'b000100,
    S_RETRY = 6'b001000,
    S_DONE  = 6'b010000,
    S_FAIL  = 6'b100000
  } state_t;

  state_t           r_state;
  logic [1:0]       r_type;
  logic [TMO_W-1:0] r_timer;
  logic [31:0]      r_header;
  logic [7:0]       r_bm;
  logic [7:0]       r_breq;
  logic [15:0]      r_wlen;
  logic             r_done;
  logic             r_fail;
  logic [1:0]       r_fail_code;
  logic [1:0]       r_retry_cnt;

  logic             w_req_ok;
  logic [7:0]       w_slot8;
  logic [31:0]      w_header;
  logic [7:0]       w_bm;
  logic [7:0]       w_breq;
  logic [15:0]      w_wlen;
  logic [TMO_W-1:0] w_tmo_load;

  assign w_slot8 = 8'(req_slot);

  // DIGESTS carries no slot, so only the other two types are range-checked.
  assign w_req_ok = (req_type != 2'd0) &&
                    ((req_type == c_TYPE_DIG) ||
                     ({{(32-SLOT_W){1'b0}}, req_slot} < 32'(NUM_SLOTS)));

  always_comb begin
    w_header = {PROTO_VER, 8'h83, w_slot8, 8'h00};
    w_bm     = 8'd128;
    w_breq   = 8'd24;
    w_wlen   = 16'd168;
    case (req_type)
      c_TYPE_DIG: begin
        w_header = {PROTO_VER, 8'h81, 8'h00, 8'h00};
        w_wlen   = 16'd260;
      end
      c_TYPE_CERT: begin
        w_header = {PROTO_VER, 8'h82, w_slot8, 8'h00};
        w_bm     = 8'd0;
        w_breq   = 8'd25;
        w_wlen   = 16'd2052;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_tmo_load = c_TMO_CHAL;
    case (r_type)
      c_TYPE_DIG:  w_tmo_load = c_TMO_DIG;
      c_TYPE_CERT: w_tmo_load = c_TMO_CERT;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_type      <= 2'd0;
      r_timer     <= '0;
      r_header    <= 32'd0;
      r_bm        <= 8'd0;
      r_breq      <= 8'd0;
      r_wlen      <= 16'd0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= 2'd0;
      r_retry_cnt <= 2'd0;
    end else if (abort) begin
      // Silent cancel: no pulses, captured fields and counters are kept.
      r_state <= S_IDLE;
      r_timer <= '0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_fail_code <= 2'd0;
            r_retry_cnt <= 2'd0;
            if (w_req_ok) begin
              r_type   <= req_type;
              r_header <= w_header;
              r_bm     <= w_bm;
              r_breq   <= w_breq;
              r_wlen   <= w_wlen;
              r_state  <= S_SEND;
            end else begin
              r_fail_code <= 2'd3;
              r_fail      <= 1'b1;
              r_state     <= S_FAIL;
            end
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            r_timer <= w_tmo_load;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A reply outranks busy, and busy outranks the timeout.
          if (rsp_valid) begin
            if (rsp_error) begin
              r_fail_code <= 2'd2;
              r_fail      <= 1'b1;
              r_state     <= S_FAIL;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (busy_in || (r_timer == '0)) begin
            if (r_retry_cnt < c_MAX_RETRY) begin
              r_state <= S_RETRY;
            end else begin
              r_fail_code <= 2'd1;
              r_fail      <= 1'b1;
              r_state     <= S_FAIL;
            end
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        S_RETRY: begin
          r_retry_cnt <= r_retry_cnt + 2'd1;
          r_state     <= S_SEND;
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAIL:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready        = (r_state == S_IDLE);
  assign tx_valid         = (r_state == S_SEND);
  assign tx_header        = r_header;
  assign tx_bmRequestType = r_bm;
  assign tx_bRequest      = r_breq;
  assign tx_wLength       = r_wlen;
  assign done             = r_done;
  assign fail             = r_fail;
  assign fail_code        = r_fail_code;
  assign retry_cnt        = r_retry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_auth_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_auth_req_sequencer
// Purpose  : Self-checking bench for auth_req_sequencer. Each request is
//            described by a per-attempt plan (reply kind and delay); the
//            expected fields, timing and outcome come from a small
//            transaction-level model of the request rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_auth_req_sequencer;

  localparam int c_MAX_RETRY = 2;

  // Per-attempt plan kinds.
  localparam int K_TMO   = 0;  // no reply, let the timer expire
  localparam int K_OK    = 1;  // good reply
  localparam int K_ERR   = 2;  // error reply
  localparam int K_BUSY  = 3;  // busy indication
  localparam int K_ABW   = 4;  // abort while waiting
  localparam int K_ABS   = 5;  // abort while sending
  localparam int K_RST   = 6;  // reset while waiting

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        abort = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'd0;
  logic [1:0]  req_slot = 2'd0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_header;
  logic [7:0]  tx_bmRequestType;
  logic [7:0]  tx_bRequest;
  logic [15:0] tx_wLength;
  logic        rsp_valid = 1'b0;
  logic        rsp_error = 1'b0;
  logic        busy_in = 1'b0;
  logic        done;
  logic        fail;
  logic [1:0]  fail_code;
  logic [1:0]  retry_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int ev_kind [0:2];
  int ev_dly  [0:2];

  always #5 clk = ~clk;

  auth_req_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .abort            (abort),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_type         (req_type),
    .req_slot         (req_slot),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .tx_header        (tx_header),
    .tx_bmRequestType (tx_bmRequestType),
    .tx_bRequest      (tx_bRequest),
    .tx_wLength       (tx_wLength),
    .rsp_valid        (rsp_valid),
    .rsp_error        (rsp_error),
    .busy_in          (busy_in),
    .done             (done),
    .fail             (fail),
    .fail_code        (fail_code),
    .retry_cnt        (retry_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference tables ----------------
  function automatic logic [31:0] exp_hdr(input logic [1:0] t, input logic [1:0] s);
    case (t)
      2'd1:    return {8'h10, 8'h83, 6'd0, s, 8'h00};
      2'd2:    return 32'h10810000;
      default: return {8'h10, 8'h82, 6'd0, s, 8'h00};
    endcase
  endfunction

  function automatic int exp_bm(input logic [1:0] t);
    return (t == 2'd3) ? 0 : 128;
  endfunction

  function automatic int exp_breq(input logic [1:0] t);
    return (t == 2'd3) ? 25 : 24;
  endfunction

  function automatic int exp_wlen(input logic [1:0] t);
    case (t)
      2'd1:    return 168;
      2'd2:    return 260;
      default: return 2052;
    endcase
  endfunction

  function automatic int exp_tmo(input logic [1:0] t);
    case (t)
      2'd1:    return 100;
      2'd2:    return 50;
      default: return 200;
    endcase
  endfunction

  task automatic clear_rsp();
    rsp_valid = 1'b0;
    rsp_error = 1'b0;
    busy_in   = 1'b0;
  endtask

  // Drives one request following ev_kind/ev_dly; n_stall < 0 means random.
  // All driving and sampling happen on the falling edge.
  task automatic run_txn(input logic [1:0] typ, input logic [1:0] slot, input int n_stall);
    int    st;
    int    d;
    int    k;
    bit    quiet;
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1;
    req_type  = typ;
    req_slot  = slot;
    @(negedge clk);
    req_valid = 1'b0;
    req_type  = 2'($urandom);
    req_slot  = 2'($urandom);
    if (typ == 2'd0 || (typ != 2'd2 && slot >= 2'd3)) begin
      check("inv_fail", fail, 1);
      check("inv_code", fail_code, 3);
      check("inv_txv", tx_valid, 0);
      @(negedge clk);
      check("inv_idle", req_ready, 1);
      check("inv_fail_end", fail, 0);
      check("inv_code_hold", fail_code, 3);
      return;
    end
    for (int a = 0; a <= c_MAX_RETRY; a++) begin
      st = (n_stall < 0) ? $urandom_range(0, 3) : n_stall;
      for (int s = 0; s <= st; s++) begin
        check("send_txv", tx_valid, 1);
        check("send_hdr", tx_header, exp_hdr(typ, slot));
        check("send_bm", tx_bmRequestType, exp_bm(typ));
        check("send_breq", tx_bRequest, exp_breq(typ));
        check("send_wlen", tx_wLength, exp_wlen(typ));
        check("send_retry", retry_cnt, a);
        check("send_code", fail_code, 0);
        if (ev_kind[a] == K_ABS) begin
          abort    = 1'b1;
          tx_ready = 1'($urandom);
          @(negedge clk);
          abort    = 1'b0;
          tx_ready = 1'b0;
          check("abs_idle", req_ready, 1);
          check("abs_txv", tx_valid, 0);
          check("abs_pulse", {done, fail}, 0);
          check("abs_retry", retry_cnt, a);
          @(negedge clk);
          check("abs_pulse2", {done, fail}, 0);
          return;
        end
        // Replies outside the wait window must be ignored.
        tx_ready  = (s == st);
        rsp_valid = 1'($urandom);
        rsp_error = 1'($urandom);
        busy_in   = 1'($urandom);
        @(negedge clk);
      end
      tx_ready = 1'b0;
      clear_rsp();
      d = (ev_kind[a] == K_TMO) ? exp_tmo(typ) : ev_dly[a];
      quiet = 1'b1;
      for (k = 0; k < d; k++) begin
        quiet &= (tx_valid == 1'b0) && (done == 1'b0) && (fail == 1'b0) && (req_ready == 1'b0);
        @(negedge clk);
      end
      check("wait_quiet", quiet, 1);
      case (ev_kind[a])
        K_OK:   begin rsp_valid = 1'b1; rsp_error = 1'b0; busy_in = 1'($urandom); end
        K_ERR:  begin rsp_valid = 1'b1; rsp_error = 1'b1; busy_in = 1'($urandom); end
        K_BUSY: busy_in = 1'b1;
        K_ABW:  begin abort = 1'b1; rsp_valid = 1'($urandom); busy_in = 1'($urandom); end
        K_RST:  begin reset = 1'b1; rsp_valid = 1'($urandom); end
        default: ;
      endcase
      @(negedge clk);
      clear_rsp();
      abort = 1'b0;
      reset = 1'b0;
      if (ev_kind[a] == K_ABW || ev_kind[a] == K_RST) begin
        check("cancel_idle", req_ready, 1);
        check("cancel_pulse", {done, fail}, 0);
        if (ev_kind[a] == K_RST) begin
          check("rst_hdr", tx_header, 0);
          check("rst_retry", retry_cnt, 0);
          check("rst_code", fail_code, 0);
        end else begin
          check("abw_retry", retry_cnt, a);
        end
        @(negedge clk);
        check("cancel_pulse2", {done, fail}, 0);
        return;
      end
      if (ev_kind[a] == K_OK || ev_kind[a] == K_ERR) begin
        check("end_done", done, (ev_kind[a] == K_OK) ? 1 : 0);
        check("end_fail", fail, (ev_kind[a] == K_ERR) ? 1 : 0);
        check("end_code", fail_code, (ev_kind[a] == K_ERR) ? 2 : 0);
        check("end_retry", retry_cnt, a);
        @(negedge clk);
        check("end_idle", req_ready, 1);
        check("end_pulse", {done, fail}, 0);
        check("end_code_hold", fail_code, (ev_kind[a] == K_ERR) ? 2 : 0);
        return;
      end
      // Busy or timeout: resend while retries remain.
      if (a == c_MAX_RETRY) begin
        check("exh_fail", fail, 1);
        check("exh_done", done, 0);
        check("exh_code", fail_code, 1);
        check("exh_retry", retry_cnt, a);
        @(negedge clk);
        check("exh_idle", req_ready, 1);
        check("exh_pulse", {done, fail}, 0);
        return;
      end
      check("retry_quiet", {tx_valid, done, fail}, 0);
      check("retry_cnt_old", retry_cnt, a);
      @(negedge clk);
    end
  endtask

  task automatic plan(input int k0, input int d0, input int k1, input int d1,
                      input int k2, input int d2);
    ev_kind[0] = k0; ev_dly[0] = d0;
    ev_kind[1] = k1; ev_dly[1] = d1;
    ev_kind[2] = k2; ev_dly[2] = d2;
  endtask

  initial begin
    logic [1:0] t;
    logic [1:0] s;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_txv", tx_valid, 0);
    check("rst_outs", {tx_header, tx_bmRequestType, tx_bRequest, tx_wLength}, 0);
    check("rst_pulses", {done, fail, fail_code, retry_cnt}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Challenge slot 1, immediate acceptance, reply 10 cycles after send.
    plan(K_OK, 10, K_OK, 0, K_OK, 0);
    run_txn(2'd1, 2'd1, 0);
    // Digests with no reply: three sends then retries exhausted.
    plan(K_TMO, 0, K_TMO, 0, K_TMO, 0);
    run_txn(2'd2, 2'd0, 0);
    // Certificate with out-of-range slot.
    run_txn(2'd3, 2'd3, 0);
    // Certificate slot 2 with transport stalled for 5 cycles.
    plan(K_OK, 3, K_OK, 0, K_OK, 0);
    run_txn(2'd3, 2'd2, 5);
    // Error reply on the same cycle the timer reaches zero.
    plan(K_ERR, 100, K_OK, 0, K_OK, 0);
    run_txn(2'd1, 2'd0, 0);
    // Busy, then abort during the resend.
    plan(K_BUSY, 4, K_ABS, 0, K_OK, 0);
    run_txn(2'd1, 2'd2, 1);
    // Reset in the middle of a wait.
    plan(K_RST, 7, K_OK, 0, K_OK, 0);
    run_txn(2'd2, 2'd1, 0);
    // Zero type is invalid.
    run_txn(2'd0, 2'd0, 0);
    // Busy on the timeout cycle of the final attempt.
    plan(K_BUSY, 0, K_TMO, 0, K_BUSY, 50);
    run_txn(2'd2, 2'd3, 2);

    for (int n = 0; n < 30; n++) begin
      t = 2'($urandom);
      s = 2'($urandom);
      for (int a = 0; a <= c_MAX_RETRY; a++) begin
        ev_kind[a] = $urandom_range(0, 6);
        ev_dly[a]  = ($urandom_range(0, 3) == 0) ? exp_tmo(t) : $urandom_range(0, 20);
      end
      run_txn(t, s, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/auth_req_sequencer.md
AUTH_REQ_SEQUENCER -- requirements
Module: auth_req_sequencer

Interface
REQ-001 Parameters SHALL be:
- NUM_SLOTS, default 3: number of valid certificate slots.
- SLOT_W, default 2: slot field width.
- TMO_W, default 16: timeout counter width.
- MAX_RETRY, default 2: retransmissions allowed after the first send.
- TMO_CHAL, default 100: challenge response timeout, in cycles.
- TMO_DIG, default 50: digests response timeout, in cycles.
- TMO_CERT, default 200: certificate response timeout, in cycles.
- PROTO_VER, default 8'h10: ProtocolVersion byte.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- abort, in, 1: synchronous cancel of the current request.
- req_valid, in, 1: request offered.
- req_ready, out, 1: request can be accepted.
- req_type, in, 2: 1 = CHALLENGE, 2 = DIGESTS, 3 = CERTIFICATE.
- req_slot, in, SLOT_W: target slot.
- tx_valid, out, 1: message valid.
- tx_ready, in, 1: transport accepts the message.
- tx_header, out, 32: {ProtocolVersion, MessageType, Param1, Param2}, MSB first.
- tx_bmRequestType, out, 8: USB bmRequestType.
- tx_bRequest, out, 8: USB bRequest.
- tx_wLength, out, 16: USB wLength.
- rsp_valid, in, 1: responder reply present.
- rsp_error, in, 1: reply is an error message.
- busy_in, in, 1: responder busy indication.
- done, out, 1: success pulse.
- fail, out, 1: failure pulse.
- fail_code, out, 2: failure cause.
- retry_cnt, out, 2: retransmissions used.

Function
REQ-003 The block SHALL have states IDLE, SEND, WAIT_RSP, RETRY, DONE and FAIL, encoded one-hot.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a clock where req_valid && req_ready.
REQ-005 On acceptance of a valid request, the tx_* fields SHALL be registered, retry_cnt SHALL clear, and the next state SHALL be SEND.
REQ-006 A request SHALL be valid when req_type is nonzero and req_slot is less than NUM_SLOTS; a DIGESTS request ignores the slot check.
REQ-007 An invalid request SHALL go IDLE->FAIL with fail_code=3 and SHALL NOT assert tx_valid.
REQ-008 Field encodings SHALL be (tx_header, tx_bmRequestType, tx_bRequest, tx_wLength):
- CHALLENGE: {PROTO_VER, 8'h83, slot, 8'h00}, 128, 24, 168.
- DIGESTS: {PROTO_VER, 8'h81, 8'h00, 8'h00}, 128, 24, 260.
- CERTIFICATE: {PROTO_VER, 8'h82, slot, 8'h00}, 0, 25, 2052.
- In each case slot is zero-extended to 8 bits.
REQ-009 tx_valid SHALL be 1 exactly in SEND; tx_* fields SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-010 The handshake tx_valid && tx_ready SHALL move SEND->WAIT_RSP and load the timer with the per-type TMO value.
REQ-011 In WAIT_RSP the timer SHALL decrement by 1 each cycle; the timeout event is the timer equal to 0 in WAIT_RSP.
REQ-012 In WAIT_RSP, rsp_valid && !rsp_error SHALL move to DONE.
REQ-013 In WAIT_RSP, rsp_valid && rsp_error SHALL move to FAIL with fail_code=2.
REQ-014 In WAIT_RSP, busy_in or a timeout SHALL move to RETRY when retry_cnt < MAX_RETRY, and to FAIL with fail_code=1 otherwise.
REQ-015 Priority within WAIT_RSP SHALL be: rsp_valid, then busy_in, then timeout.
REQ-016 RETRY SHALL last one cycle, increment retry_cnt, and go to SEND with tx_* unchanged.
REQ-017 DONE and FAIL SHALL each last one cycle, with done=1 and fail=1 respectively, and SHALL then go to IDLE.
REQ-018 fail_code SHALL hold its value until the next acceptance and SHALL be cleared on acceptance.
REQ-019 abort=1 in any state SHALL force IDLE on the next clock with no done or fail pulse; reset has priority over abort.
REQ-020 rsp_valid and busy_in SHALL be ignored outside WAIT_RSP.
REQ-021 The timer SHALL saturate at 0 and SHALL NOT wrap.

Reset
REQ-022 While reset=1, at each clock the block SHALL enter IDLE, and the registered outputs (tx_*, done, fail, fail_code, retry_cnt, timer) SHALL be 0; req_ready=1 and tx_valid=0 follow from IDLE.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction with no done or fail pulse.

Verification
REQ-024 CHALLENGE, slot 1, tx_ready=1, rsp_valid 10 cycles after the send -> tx_header=32'h10830100, wLength=168; done pulses once; retry_cnt=0.
REQ-025 DIGESTS with no response -> 51 cycles in WAIT_RSP per attempt; 3 sends total; fail=1 with fail_code=1; retry_cnt=2.
REQ-026 CERTIFICATE, slot 3 (NUM_SLOTS=3) -> fail with fail_code=3 one cycle after acceptance; tx_valid never asserted.
REQ-027 CERTIFICATE, slot 2, tx_ready held 0 for 5 cycles -> tx_valid=1 with fields stable (8'h00, 8'd25, 16'd2052) throughout, then WAIT_RSP.
REQ-028 rsp_valid=1 with rsp_error=1 on the same cycle the timer hits 0 -> FAIL with fail_code=2, no retry.
REQ-029 busy_in pulse in WAIT_RSP, then abort during the resend -> retry_cnt=1; IDLE next cycle; neither done nor fail pulses.
